move_entry: RTL

//  Player-side move initiator for the tic-tac-toe game core.
//  - Turns raw board buttons (next / select / clear) into debounced single-cycle pulses.
//  - Keeps a cursor over cells 0..8 and tracks whose turn it is.
//  - Checks the selected cell against the core's occupancy vector.
//  - Presents a legal move {player, cell} to the core on a valid/ready handshake.
//  - Sits between the board pushbuttons and the game core's move input.

---
 rtl/ttt_pkg.sv | 10 +
 rtl/move_entry_if.sv | 9 +
 rtl/move_entry_btn_debounce.sv | 37 +++
 rtl/move_entry.sv | 90 +++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe types, board size and cursor-step helper.
package ttt_pkg;
  typedef enum logic {P1, P2} player_t;
  typedef logic [3:0] cell_t;
  localparam int NUM_CELLS = 9;
  typedef enum logic [1:0] {ME_IDLE, ME_SEND, ME_LOCKED} me_state_t;
  function automatic cell_t next_cell(cell_t c);
    return (c == cell_t'(NUM_CELLS - 1)) ? cell_t'(0) : c + cell_t'(1);
  endfunction
endpackage

// File: rtl/move_entry_if.sv
// move_entry_if: valid/ready move handshake between move_entry and the game core.
interface move_entry_if import ttt_pkg::*; ();
  logic    move_valid;
  logic    move_ready;
  cell_t   move_cell;
  player_t move_player;
  modport master(output move_valid, move_cell, move_player, input move_ready);
  modport slave(input move_valid, move_cell, move_player, output move_ready);
endinterface

// File: rtl/move_entry_btn_debounce.sv
// btn_debounce: synchronise a raw button and emit one pulse per stable press.
module btn_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press_pulse
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [1:0]    sync_q;
  logic          prev_q, lvl_q, lvl_d, pulse_q, pulse_d, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // lvl_q only follows the input after it has been stable, so a release must settle too
  always_comb begin
    done    = cnt_q == CW'(CYCLES);
    cnt_d   = (sync_q[1] != prev_q) ? '0 : done ? cnt_q : cnt_q + CW'(1);
    lvl_d   = done ? prev_q : lvl_q;
    pulse_d = done && prev_q && !lvl_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      prev_q  <= sync_q[1];
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
    end
  end
  assign press_pulse = pulse_q;
endmodule

// File: rtl/move_entry.sv
// move_entry: turns board buttons into legal {player, cell} moves offered to the game core.
module move_entry import ttt_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_sel,
  input  logic                 btn_clr,
  input  logic [NUM_CELLS-1:0] board_occ,
  input  logic                 game_over,
  move_entry_if.master         mv,
  output cell_t                cursor,
  output player_t              turn,
  output logic                 reject,
  output logic                 new_game
);
  logic      next_p, sel_p, clr_p;
  me_state_t state_q, state_d;
  cell_t     cursor_q, cursor_d, cell_q, cell_d;
  player_t   turn_q, turn_d, player_q, player_d;
  logic      valid_q, valid_d, reject_q, reject_d, new_game_q, new_game_d;
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .raw(btn_next), .press_pulse(next_p));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel  (.clk(clk), .rst(rst), .raw(btn_sel),  .press_pulse(sel_p));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr  (.clk(clk), .rst(rst), .raw(btn_clr),  .press_pulse(clr_p));
  // clr overrides everything; in IDLE sel wins over game_over and next
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    turn_d     = turn_q;
    valid_d    = valid_q;
    cell_d     = cell_q;
    player_d   = player_q;
    reject_d   = 1'b0;
    new_game_d = 1'b0;
    if (clr_p) begin
      state_d    = ME_IDLE;
      cursor_d   = '0;
      turn_d     = P1;
      valid_d    = 1'b0;
      new_game_d = 1'b1;
    end else if (state_q == ME_IDLE) begin
      if (sel_p) begin
        reject_d = board_occ[cursor_q];
        if (!board_occ[cursor_q]) begin
          state_d  = ME_SEND;
          valid_d  = 1'b1;
          cell_d   = cursor_q;
          player_d = turn_q;
        end
      end else if (game_over) begin
        state_d = ME_LOCKED;
      end else if (next_p) begin
        cursor_d = next_cell(cursor_q);
      end
    end else if (state_q == ME_SEND && mv.move_ready) begin
      valid_d = 1'b0;
      turn_d  = (turn_q == P1) ? P2 : P1;
      state_d = game_over ? ME_LOCKED : ME_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ME_IDLE;
      cursor_q   <= '0;
      turn_q     <= P1;
      valid_q    <= 1'b0;
      cell_q     <= '0;
      player_q   <= P1;
      reject_q   <= 1'b0;
      new_game_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      turn_q     <= turn_d;
      valid_q    <= valid_d;
      cell_q     <= cell_d;
      player_q   <= player_d;
      reject_q   <= reject_d;
      new_game_q <= new_game_d;
    end
  end
  assign mv.move_valid  = valid_q;
  assign mv.move_cell   = cell_q;
  assign mv.move_player = player_q;
  assign cursor         = cursor_q;
  assign turn           = turn_q;
  assign reject         = reject_q;
  assign new_game       = new_game_q;
endmodule
